// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: NCH independent channels, each
// producing a registered square wave (slow_clock) and a toggle pulse (tick).
// Half-period of a channel is (active limit + 1) clk cycles.
//
// Latency: slow_clock/tick change one clk after the wrap condition is seen.
// cfg_ack follows an accepted write by one clk.
// Backpressure: none. Writes are always accepted for in-range channels.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   ch_en       per-channel run enable
//   cfg_wr      one-cycle limit write strobe
//   cfg_ch      target channel of cfg_wr; out-of-range indices are ignored
//   cfg_limit   new limit value for the target channel
//   sync        (only with CLKDIV_SYNC_EN) realign all enabled channels
//   cfg_ack     one-cycle acknowledge of an accepted write
//   slow_clock  per-channel divided clock, registered
//   tick        per-channel pulse, high in the cycle slow_clock changes
//
// Optional feature macro: CLKDIV_SYNC_EN adds the sync input.

module clock_divider_multi #(
    parameter int NCH           = 4,
    parameter int DIV_W         = 32,
    parameter int DEFAULT_LIMIT = 50000
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NCH-1:0]                        ch_en,
    input  logic                                  cfg_wr,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                      cfg_limit,
`ifdef CLKDIV_SYNC_EN
    input  logic                                  sync,
`endif
    output logic                                  cfg_ack,
    output logic [NCH-1:0]                        slow_clock,
    output logic [NCH-1:0]                        tick
);

    localparam logic [DIV_W-1:0] DEF_LIM = DIV_W'(DEFAULT_LIMIT);

    // Per-channel state
    logic [DIV_W-1:0] cnt_q  [NCH];
    logic [DIV_W-1:0] cnt_d  [NCH];
    logic [DIV_W-1:0] act_q  [NCH];
    logic [DIV_W-1:0] act_d  [NCH];
    logic [DIV_W-1:0] pend_q [NCH];
    logic [DIV_W-1:0] pend_d [NCH];
    logic [NCH-1:0]   slow_q;
    logic [NCH-1:0]   slow_d;
    logic [NCH-1:0]   tick_q;
    logic [NCH-1:0]   tick_d;
    logic             ack_q;
    logic             ack_d;

    logic             sync_w;
    logic             cfg_in_range;
    logic [NCH-1:0]   wr_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    // cfg_ch is wide enough to address indices beyond NCH when NCH is not
    // a power of two; those writes must leave every channel untouched.
    assign cfg_in_range = (32'(cfg_ch) < 32'(NCH));
    assign ack_d        = cfg_wr && cfg_in_range;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = ack_d && (32'(cfg_ch) == 32'(i));

            // A write in the wrap cycle must land in the new active limit,
            // so the active limit is always loaded from pend_d, not pend_q.
            pend_d[i] = wr_hit[i] ? cfg_limit : pend_q[i];

            cnt_d[i]  = cnt_q[i];
            act_d[i]  = act_q[i];
            slow_d[i] = slow_q[i];
            tick_d[i] = 1'b0;

            if (!ch_en[i]) begin
                // Idle channel: park at the start state and adopt the
                // pending limit right away, since no half-period is running.
                cnt_d[i]  = '0;
                slow_d[i] = 1'b0;
                act_d[i]  = pend_d[i];
            end else if (sync_w) begin
                // Realign: restart from the start state with no tick.
                cnt_d[i]  = '0;
                slow_d[i] = 1'b0;
                act_d[i]  = pend_d[i];
            end else if (cnt_q[i] == act_q[i]) begin
                // Wrap. The counter never exceeds the active limit because
                // the limit only changes when the counter restarts at 0,
                // so an all-ones limit cannot overflow.
                cnt_d[i]  = '0;
                slow_d[i] = ~slow_q[i];
                tick_d[i] = 1'b1;
                act_d[i]  = pend_d[i];
            end else begin
                cnt_d[i]  = cnt_q[i] + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                act_q[i]  <= DEF_LIM;
                pend_q[i] <= DEF_LIM;
            end
            slow_q <= '0;
            tick_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                act_q[i]  <= act_d[i];
                pend_q[i] <= pend_d[i];
            end
            slow_q <= slow_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
        end
    end

    assign slow_clock = slow_q;
    assign tick       = tick_q;
    assign cfg_ack    = ack_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: two instances (NCH=4 and
// NCH=3, DIV_W=8, DEFAULT_LIMIT=3) share stimulus; a deadline-based model
// predicts slow_clock, tick and cfg_ack every cycle.

module tb_clock_divider_multi;

    localparam int DIV_W = 8;
    localparam int DEFL  = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [3:0]       ch_en = '0;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [DIV_W-1:0] cfg_limit = '0;
    logic             sync_s = 1'b0;

    logic             ack_a, ack_b;
    logic [3:0]       slow_a, tick_a;
    logic [2:0]       slow_b, tick_b;

    always #5 clk = ~clk;

    clock_divider_multi #(.NCH(4), .DIV_W(DIV_W), .DEFAULT_LIMIT(DEFL)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_en      (ch_en),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_limit  (cfg_limit),
`ifdef CLKDIV_SYNC_EN
        .sync       (sync_s),
`endif
        .cfg_ack    (ack_a),
        .slow_clock (slow_a),
        .tick       (tick_a)
    );

    clock_divider_multi #(.NCH(3), .DIV_W(DIV_W), .DEFAULT_LIMIT(DEFL)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_en      (ch_en[2:0]),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_limit  (cfg_limit),
`ifdef CLKDIV_SYNC_EN
        .sync       (sync_s),
`endif
        .cfg_ack    (ack_b),
        .slow_clock (slow_b),
        .tick       (tick_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: each running channel has an absolute edge index at
    // which it next toggles; limits are plain integers.
    int nch_m [2] = '{4, 3};
    int act_m  [2][4];
    int pend_m [2][4];
    int dl_m   [2][4];
    bit run_m  [2][4];
    bit slow_m [2][4];
    bit tick_m [2][4];
    bit ack_m  [2];
    int cyc = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ack_m[d] = 0;
            for (int c = 0; c < 4; c++) begin
                act_m[d][c] = DEFL; pend_m[d][c] = DEFL; dl_m[d][c] = 0;
                run_m[d][c] = 0; slow_m[d][c] = 0; tick_m[d][c] = 0;
            end
        end
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_edge();
        bit wr;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            ack_m[d] = cfg_wr && (int'(cfg_ch) < nch_m[d]);
            for (int c = 0; c < nch_m[d]; c++) begin
                wr = cfg_wr && (int'(cfg_ch) == c);
                if (wr) pend_m[d][c] = int'(cfg_limit);
                tick_m[d][c] = 0;
                if (!ch_en[c]) begin
                    run_m[d][c] = 0; slow_m[d][c] = 0; act_m[d][c] = pend_m[d][c];
                end else if (sync_s) begin
                    run_m[d][c] = 1; slow_m[d][c] = 0; act_m[d][c] = pend_m[d][c];
                    dl_m[d][c] = cyc + 1 + act_m[d][c];
                end else begin
                    if (!run_m[d][c]) begin
                        run_m[d][c] = 1;
                        dl_m[d][c]  = cyc + act_m[d][c];
                    end
                    if (cyc == dl_m[d][c]) begin
                        slow_m[d][c] = ~slow_m[d][c];
                        tick_m[d][c] = 1;
                        act_m[d][c]  = pend_m[d][c];
                        dl_m[d][c]   = cyc + act_m[d][c] + 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] es_a, et_a;
        logic [2:0] es_b, et_b;
        for (int c = 0; c < 4; c++) begin
            es_a[c] = slow_m[0][c]; et_a[c] = tick_m[0][c];
        end
        for (int c = 0; c < 3; c++) begin
            es_b[c] = slow_m[1][c]; et_b[c] = tick_m[1][c];
        end
        check_eq("slow_a", 32'(slow_a), 32'(es_a));
        check_eq("tick_a", 32'(tick_a), 32'(et_a));
        check_eq("ack_a",  32'(ack_a),  32'(ack_m[0]));
        check_eq("slow_b", 32'(slow_b), 32'(es_b));
        check_eq("tick_b", 32'(tick_b), 32'(et_b));
        check_eq("ack_b",  32'(ack_b),  32'(ack_m[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_lim(input int ch, input int lim);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_limit = DIV_W'(lim);
        step();
        cfg_wr = 1'b0;
    endtask

    // Asynchronous reset pulse applied between edges; outputs must clear
    // before the next clock edge.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_slow_a", 32'(slow_a), 32'd0);
        check_eq("rst_tick_a", 32'(tick_a), 32'd0);
        check_eq("rst_ack_a",  32'(ack_a),  32'd0);
        check_eq("rst_slow_b", 32'(slow_b), 32'd0);
        run(2);
        cfg_wr  = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        #2;
        pulse_reset();
        run(2);

        // All channels at the default limit of 3: toggle every 4 cycles.
        ch_en = 4'hF;
        run(20);

        // New limit on ch1 mid half-period; current half-period unaffected.
        run(2);
        write_lim(1, 9);
        run(45);

        // Write limit 0 to ch1 on the very edge where ch1 wraps.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (cyc + 1 == dl_m[0][1]) found = 1;
            else step();
        end
        if (!found) begin
            n_errors++;
            $display("FAIL wrap_align: ch1 wrap not reached within bound");
        end
        write_lim(1, 0);
        run(12);

        // cfg_ch=3: out of range for the 3-channel instance, ch3 of the other.
        write_lim(3, 255);
        run(540);

        // Back-to-back writes: only the last one survives.
        write_lim(0, 7);
        write_lim(0, 2);
        run(20);

        // Channel 2 off for 5 cycles, then back on.
        ch_en[2] = 1'b0;
        run(5);
        ch_en[2] = 1'b1;
        run(20);

        // Reset in the middle of a period with a write in flight.
        run(3);
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_limit = 8'd11;
        pulse_reset();
        run(30);

`ifdef CLKDIV_SYNC_EN
        // Stagger channels, then realign them with sync.
        ch_en = 4'h0;
        run(2);
        for (int c = 0; c < 4; c++) write_lim(c, 5);
        ch_en[0] = 1'b1; run(3);
        ch_en[1] = 1'b1; run(2);
        ch_en[2] = 1'b1; ch_en[3] = 1'b1; run(7);
        sync_s = 1'b1;
        step();
        sync_s = 1'b0;
        run(30);
        check_eq("lockstep_0_3", 32'(slow_a[0]), 32'(slow_a[3]));
`endif

        // Randomized traffic.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                int b;
                b = int'($urandom_range(0, 3));
                ch_en[b] = ~ch_en[b];
            end
            if ($urandom_range(0, 5) == 0) begin
                cfg_wr    = 1'b1;
                cfg_ch    = 2'($urandom_range(0, 3));
                cfg_limit = DIV_W'($urandom_range(0, 12));
            end else begin
                cfg_wr = 1'b0;
            end
`ifdef CLKDIV_SYNC_EN
            sync_s = ($urandom_range(0, 99) == 0);
`endif
            step();
        end
        cfg_wr = 1'b0;
        sync_s = 1'b0;
        run(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
